// File: rtl/mips_cpu_muldiv_unit.sv
// rtl/mips_cpu_muldiv_unit.sv - iterative multiply/divide unit owning HI/LO
module mips_cpu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_lo;   // negate product (mul) or quotient (div)
    logic               r_neg_rem;  // negate remainder (div only)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // Operand conditioning at accept time
    logic               w_signed;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic               w_rt_zero;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;

    assign w_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign w_rs_neg  = w_signed & rs[WIDTH-1];
    assign w_rt_neg  = w_signed & rt[WIDTH-1];
    assign w_rt_zero = (rt == '0);
    assign w_rs_mag  = w_rs_neg ? -rs : rs;
    assign w_rt_mag  = w_rt_neg ? -rt : rt;

    // One radix-2 multiply step: conditionally add, then shift right
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

    // One restoring divide step: shift left, trial subtract, keep if it fits
    logic [WIDTH:0]     w_drem;
    logic [WIDTH:0]     w_ddiff;
    logic               w_dfit;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_drem     = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ddiff    = w_drem - {1'b0, r_opnd};
    assign w_dfit     = ~w_ddiff[WIDTH];
    assign w_div_next = {(w_dfit ? w_ddiff[WIDTH-1:0] : w_drem[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_dfit};

    // Sign fix-up of the finished magnitude result
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_raw;
    logic [WIDTH-1:0]   w_rem_raw;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod    = r_neg_lo ? -r_acc : r_acc;
    assign w_quo_raw = r_acc[WIDTH-1:0];
    assign w_rem_raw = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo     = r_neg_lo  ? -w_quo_raw : w_quo_raw;
    assign w_rem     = r_neg_rem ? -w_rem_raw : w_rem_raw;

    // Control FSM, iteration datapath and HI/LO write-back
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (clk_enable) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: r_hi <= rs;
                            OP_MTLO: r_lo <= rs;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_is_div  <= op[1];
                                r_cnt     <= '0;
                                r_state   <= S_RUN;
                                r_busy    <= 1'b1;
                                r_neg_rem <= w_rs_neg;
                                if (op[1]) begin
                                    // divide by zero keeps an all-ones quotient unsigned
                                    r_neg_lo <= (w_rs_neg ^ w_rt_neg) & ~w_rt_zero;
                                    r_opnd   <= w_rt_mag;
                                    r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
                                end else begin
                                    r_neg_lo <= w_rs_neg ^ w_rt_neg;
                                    r_opnd   <= w_rs_mag;
                                    r_acc    <= {{WIDTH{1'b0}}, w_rt_mag};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!abort) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// tb/tb_mips_cpu_muldiv_unit.sv - scoreboard testbench for mips_cpu_muldiv_unit
module tb_mips_cpu_muldiv_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, clk_enable, start, abort;
    logic [2:0]   op;
    logic [W-1:0] rs, rt;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    logic         start8;
    logic [2:0]   op8;
    logic [7:0]   rs8, rt8;
    logic         abort8;
    logic         busy8, done8;
    logic [7:0]   hi8, lo8;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q[$];
    exp_t q8[$];
    logic prev_done = 1'b0;
    logic prev_done8 = 1'b0;
    int   nb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_cpu_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
        .op(op), .rs(rs), .rt(rt), .abort(abort),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mips_cpu_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start8),
        .op(op8), .rs(rs8), .rt(rt8), .abort(abort8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    // Called at a negedge; drives one request, returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int extra, input bit expect_done);
        exp_t e;
        start = 1'b1; op = o; rs = a; rt = b;
        if (expect_done) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cyc + W + 2 + extra;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int nbusy);
        nbusy = 0;
        while (busy && nbusy < 200) begin
            nbusy++;
            @(negedge clk);
        end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Monitor: compare each new done pulse against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (done && !prev_done) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_done actual hi=%h lo=%h expected no done", hi, lo);
            end else begin
                e = q.pop_front();
                chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
                chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        prev_done = done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8 && !prev_done8) begin
            if (q8.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_done8 actual hi=%h lo=%h expected no done", hi8, lo8);
            end else begin
                e = q8.pop_front();
                chk("result8_hi", {56'd0, hi8}, {32'd0, e.hi});
                chk("result8_lo", {56'd0, lo8}, {32'd0, e.lo});
                chk("done8_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        prev_done8 = done8;
    end

    initial begin
        exp_t e8;
        reset = 1'b0; clk_enable = 1'b1; start = 1'b0; abort = 1'b0;
        op = 3'd0; rs = '0; rt = '0;
        start8 = 1'b0; op8 = 3'd0; rs8 = '0; rt8 = '0; abort8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // signed multiply, with busy length
        issue(3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 1'b1);
        wait_idle(nb);
        chk("mult_busy_cycles", 64'(nb), 64'd33);

        // unsigned vs signed all-ones, hi/lo hold while busy
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1'b1);
        repeat (5) @(negedge clk);
        chk("hold_hi_busy", {32'd0, hi}, 64'hFFFFFFFF);
        chk("hold_lo_busy", {32'd0, lo}, 64'hFFFFFFF1);
        wait_idle(nb);
        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 1'b1);
        wait_idle(nb);

        // divides
        issue(3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b1);
        wait_idle(nb);
        issue(3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 0, 1'b1);
        wait_idle(nb);

        // boundary divides
        issue(3'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 0, 1'b1);
        wait_idle(nb);
        chk("divz_busy_cycles", 64'(nb), 64'd33);
        issue(3'd2, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 0, 1'b1);
        wait_idle(nb);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1'b1);
        wait_idle(nb);

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; op = 3'd4; rs = 32'hAAAA5555;
        @(negedge clk);
        chk("mthi_hi", {32'd0, hi}, 64'hAAAA5555);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        op = 3'd5; rs = 32'h0000BEEF;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", {32'd0, lo}, 64'h0000BEEF);
        chk("mtlo_hi", {32'd0, hi}, 64'hAAAA5555);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        chk("mtlo_done", {63'd0, done}, 64'd0);

        // start during RUN is ignored
        issue(3'd0, 32'd7, 32'd6, 32'h00000000, 32'h0000002A, 0, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd7;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle(nb);
        chk("ignored_start_busy", 64'(nb), 64'd25);

        // back-to-back: second start issued in the done cycle
        issue(3'd0, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 0, 1'b1);
        wait_idle(nb);
        chk("b2b_done_cycle_flag", {63'd0, done}, 64'd1);
        issue(3'd0, 32'hFFFFFFFE, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFEE, 0, 1'b1);
        wait_idle(nb);

        // abort together with start in IDLE: accepted normally
        abort = 1'b1;
        issue(3'd1, 32'h10, 32'h10, 32'h00000000, 32'h00000100, 0, 1'b1);
        abort = 1'b0;
        wait_idle(nb);

        // abort at iteration 10
        issue(3'd1, 32'd5, 32'd5, 32'd0, 32'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'h0);
        chk("abort_lo", {32'd0, lo}, 64'h100);
        repeat (40) @(negedge clk);
        chk("abort_lo_later", {32'd0, lo}, 64'h100);

        // reset mid-RUN
        issue(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 0, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midreset_hi", {32'd0, hi}, 64'd0);
        chk("midreset_lo", {32'd0, lo}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("midreset_idle", {63'd0, busy}, 64'd0);

        // clk_enable low for 5 cycles mid-RUN delays done by exactly 5
        issue(3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 1'b1);
        repeat (10) @(negedge clk);
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        clk_enable = 1'b1;
        wait_idle(nb);

        // 8-bit instance: -128 * -128
        start8 = 1'b1; op8 = 3'd0; rs8 = 8'h80; rt8 = 8'h80;
        e8.hi = 32'h40; e8.lo = 32'h00; e8.cyc = cyc + 10;
        q8.push_back(e8);
        @(negedge clk);
        start8 = 1'b0;
        nb = 0;
        while (busy8 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("w8_busy_cycles", 64'(nb), 64'd9);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        chk("scoreboard8_empty", 64'(q8.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
